// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data widths, reset PC, fetch FSM states and the
// opcode constants the decoder shares with the fetch unit.
package cpu_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        FETCH,
        DRAIN
    } fetch_state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    // One buffered fetch: the word and the address of the following word.
    typedef struct packed {
        logic [INSTR_W-1:0] word;
        logic [31:0]        pc_plus4;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry fetch FIFO with flush. Slot 0 is always the head, so the head
// outputs come straight from a register; empty slots are held at zero.
module fetch_buffer
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_entry,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    logic [1:0]   count_q, count_d;
    fetch_entry_t slot_q [2];
    fetch_entry_t slot_d [2];

    always_comb begin
        count_d = count_q;
        slot_d  = slot_q;
        if (flush) begin
            count_d   = '0;
            slot_d[0] = '0;
            slot_d[1] = '0;
        end else begin
            if (pop) begin
                slot_d[0] = slot_q[1];
                slot_d[1] = '0;
                count_d   = count_q - 2'd1;
            end
            // Append after the pop so a push+pop at count 2 lands in slot 1.
            if (push && (count_d != 2'd2)) begin
                slot_d[count_d[0]] = push_entry;
                count_d            = count_d + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            slot_q[0] <= '0;
            slot_q[1] <= '0;
        end else begin
            count_q   <= count_d;
            slot_q[0] <= slot_d[0];
            slot_q[1] <= slot_d[1];
        end
    end

    assign count = count_q;
    assign head  = slot_q[0];

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: PC, req/ack memory handshake, 2-word buffer and
// branch redirect. Define IFETCH_PERF_CNT_EN to add FetchCount/FlushCount.
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        PCSrc,
    input  logic [31:0] BranchTarget,
    input  logic        Stall,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemAck,
    input  logic [31:0] IMemData,
    output logic [31:0] Instruction,
    output logic [31:0] PCPlus4,
    output logic        InstrValid
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0] FetchCount,
    output logic [31:0] FlushCount
`endif
);

    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  target_q, target_d;
    logic         pending_q, pending_d;
    logic [31:0]  branch_aligned;
    logic         push, pop, flush;
    logic [1:0]   count;
    fetch_entry_t head;
    fetch_entry_t push_entry;

    assign branch_aligned = BranchTarget & ALIGN_MASK;
    assign InstrValid     = (count != 2'd0);
    assign pop            = InstrValid & ~Stall;
    assign flush          = PCSrc;
    assign IMemAddr       = pc_q;
    assign push_entry     = '{word: IMemData, pc_plus4: pc_q + 32'd4};

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        target_d = target_q;
        push     = 1'b0;
        IMemReq  = 1'b0;
        unique case (state_q)
            FETCH: begin
                // pending_q keeps an unacknowledged request alive even if
                // the buffer fills or the consumer stalls meanwhile.
                IMemReq = ~Rst & (pending_q | (count < 2'd2) | pop);
                if (PCSrc) begin
                    if (IMemReq && !IMemAck) begin
                        target_d = branch_aligned;
                        state_d  = DRAIN;
                    end else begin
                        pc_d = branch_aligned;
                    end
                end else if (IMemReq && IMemAck) begin
                    push = 1'b1;
                    pc_d = pc_q + 32'd4;
                end
            end
            DRAIN: begin
                IMemReq = ~Rst;
                if (IMemAck) begin
                    pc_d    = PCSrc ? branch_aligned : target_q;
                    state_d = FETCH;
                end else if (PCSrc) begin
                    target_d = branch_aligned;
                end
            end
            default: state_d = FETCH;
        endcase
        pending_d = IMemReq & ~IMemAck;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC & ALIGN_MASK;
            target_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            target_q  <= target_d;
            pending_q <= pending_d;
        end
    end

    fetch_buffer u_fetch_buffer (
        .clk        (Clk),
        .rst        (Rst),
        .push       (push),
        .pop        (pop),
        .flush      (flush),
        .push_entry (push_entry),
        .count      (count),
        .head       (head)
    );

    assign Instruction = head.word;
    assign PCPlus4     = head.pc_plus4;

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q + (push ? 32'd1 : 32'd0);
        flush_cnt_d = flush_cnt_q + (PCSrc ? 32'd1 : 32'd0);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign FetchCount = fetch_cnt_q;
    assign FlushCount = flush_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a scoreboard of expected
// instruction words and a wait-state-configurable memory model.
module tb_instruction_fetch;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        PCSrc = 1'b0;
    logic [31:0] BranchTarget = '0;
    logic        Stall = 1'b0;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemAck;
    logic [31:0] IMemData;
    logic [31:0] Instruction;
    logic [31:0] PCPlus4;
    logic        InstrValid;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] FetchCount;
    logic [31:0] FlushCount;
`endif

    int unsigned waits = 0;
    int unsigned wcnt = 0;
    int unsigned ack_cnt = 0;
    int unsigned ack_base;
    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;
    exp_t exp_q [$];

    instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .PCSrc        (PCSrc),
        .BranchTarget (BranchTarget),
        .Stall        (Stall),
        .IMemReq      (IMemReq),
        .IMemAddr     (IMemAddr),
        .IMemAck      (IMemAck),
        .IMemData     (IMemData),
        .Instruction  (Instruction),
        .PCPlus4      (PCPlus4),
        .InstrValid   (InstrValid)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .FetchCount   (FetchCount),
        .FlushCount   (FlushCount)
`endif
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Memory: acks after `waits` extra cycles of a held request.
    always_comb begin
        IMemAck  = IMemReq && (wcnt == waits);
        IMemData = IMemAck ? mem_word(IMemAddr) : 32'hDEAD_BEEF;
    end

    always @(posedge Clk) begin
        if (IMemReq && !IMemAck) wcnt <= wcnt + 1;
        else                     wcnt <= 0;
        if (IMemReq && IMemAck)  ack_cnt <= ack_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_word(input logic [31:0] addr);
        exp_t e;
        e.instr = mem_word(addr);
        e.pc4   = addr + 32'd4;
        exp_q.push_back(e);
    endtask

    // Monitor: every consumed word must match the scoreboard head.
    always @(negedge Clk) begin
        if (!Rst && InstrValid && !Stall) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_instr: got %h pc4 %h expected none", Instruction, PCPlus4);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("instr", Instruction, e.instr);
                check("pcplus4", PCPlus4, e.pc4);
            end
        end else if (!Rst && (InstrValid === 1'b0)) begin
            check("instr_zero_when_invalid", Instruction, 32'h0);
            check("pcplus4_zero_when_invalid", PCPlus4, 32'h0);
        end
    end

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    // Leaves the bench at drive time of the first cycle with Rst=0 (C0).
    task automatic rst_dut();
        cyc();
        Rst = 1'b1;
        PCSrc = 1'b0;
        Stall = 1'b0;
        waits = 0;
        cyc();
        cyc();
        #1;
        check("rst_instrvalid", {31'b0, InstrValid}, 32'h0);
        check("rst_instruction", Instruction, 32'h0);
        check("rst_pcplus4", PCPlus4, 32'h0);
        check("rst_imemreq", {31'b0, IMemReq}, 32'h0);
        cyc();
        Rst = 1'b0;
    endtask

    task automatic drained(input string name);
        check(name, exp_q.size(), 32'h0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        // Sequential zero-wait fetch
        rst_dut();
        expect_word(32'h0); expect_word(32'h4); expect_word(32'h8);
        #1;
        check("seq_addr_c0", IMemAddr, 32'h0);
        check("seq_req_c0", {31'b0, IMemReq}, 32'h1);
        cyc(); #1; check("seq_addr_c1", IMemAddr, 32'h4);
        cyc(); #1; check("seq_addr_c2", IMemAddr, 32'h8);
        cyc();
        cyc(); Stall = 1'b1;
        cyc(); drained("seq_drained");

        // Stall from reset: two words accepted, then requests stop
        rst_dut();
        Stall = 1'b1;
        ack_base = ack_cnt;
        expect_word(32'h0); expect_word(32'h4);
        cyc();
        cyc(); #1; check("stall_req_c2", {31'b0, IMemReq}, 32'h0);
        cyc(); #1;
        check("stall_req_c3", {31'b0, IMemReq}, 32'h0);
        check("stall_held_instr", Instruction, mem_word(32'h0));
        check("stall_ack_count", ack_cnt - ack_base, 32'd2);
        cyc(); Stall = 1'b0; #1;
        check("stall_resume_addr", IMemAddr, 32'h8);
        check("stall_resume_req", {31'b0, IMemReq}, 32'h1);
        cyc();
        cyc(); Stall = 1'b1;
        cyc(); drained("stall_drained");

        // Redirect coincident with ack (unaligned target), then redirect
        // during a waited request, then reset with a request outstanding
        rst_dut();
        PCSrc = 1'b1; BranchTarget = 32'h0000_0013;
        expect_word(32'h40);
        cyc(); PCSrc = 1'b0; waits = 2; #1;
        check("coinc_valid_dropped", {31'b0, InstrValid}, 32'h0);
        check("coinc_addr_target", IMemAddr, 32'h10);
        cyc(); PCSrc = 1'b1; BranchTarget = 32'h0000_0040;
        cyc(); PCSrc = 1'b0; #1;
        check("drain_addr_held", IMemAddr, 32'h10);
        check("drain_req_held", {31'b0, IMemReq}, 32'h1);
        check("drain_valid", {31'b0, InstrValid}, 32'h0);
        cyc(); #1; check("drain_next_addr", IMemAddr, 32'h40);
        cyc();
        cyc();
        cyc(); #1; check("drain_target_pcplus4", PCPlus4, 32'h44);
        cyc(); Stall = 1'b1;
        cyc();
        cyc();
        cyc(); Rst = 1'b1; #1;
        check("midreq_rst_req", {31'b0, IMemReq}, 32'h0);
        cyc(); #1;
        check("midreq_rst_valid", {31'b0, InstrValid}, 32'h0);
        check("midreq_rst_instr", Instruction, 32'h0);
        check("midreq_rst_req2", {31'b0, IMemReq}, 32'h0);
        cyc(); Rst = 1'b0; #1;
        check("midreq_release_addr", IMemAddr, 32'h0);
        check("midreq_release_req", {31'b0, IMemReq}, 32'h1);
        cyc();
        drained("redirect_drained");

        // PC wrap at the top of the address space
        rst_dut();
        PCSrc = 1'b1; BranchTarget = 32'hFFFF_FFFF;
        expect_word(32'hFFFF_FFFC); expect_word(32'h0);
        cyc(); PCSrc = 1'b0; #1; check("wrap_addr_top", IMemAddr, 32'hFFFF_FFFC);
        cyc(); #1; check("wrap_addr_zero", IMemAddr, 32'h0);
        cyc();
        cyc(); Stall = 1'b1;
        cyc(); drained("wrap_drained");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
